ram_stream_reader: RTL and testbench

- Read-side master for the single-port 32-bit data RAM (weights/image store).
- On a start command, walks a contiguous word range and emits it as a valid/ready stream to the compute datapath.
- Hides the RAM's 1-cycle registered read latency and absorbs downstream backpressure with no lost or duplicated words.

---
 rtl/ram_stream_reader_pkg.sv | 15 +
 rtl/ram_stream_reader_if.sv | 33 +++
 rtl/ram_stream_reader_skid_fifo2.sv | 56 +++++
 rtl/ram_stream_reader.sv | 164 ++++++++++++++++
 tb/tb_ram_stream_reader.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader: sequencer state encoding and
// the default RAM geometry used wherever the data RAM is instantiated.
package ram_stream_reader_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_LEN_W  = 12;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ram_stream_reader_if.sv
// RAM read port plus output stream of the reader; master = the reader,
// slave = the RAM/stream sink side.
interface ram_stream_reader_if
    import ram_stream_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output ram_we, ram_addr, ram_data_in,
        input  ram_data_out,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    modport slave (
        input  ram_we, ram_addr, ram_data_in,
        output ram_data_out,
        input  out_valid, out_data, out_last,
        output out_ready
    );

endinterface

// File: rtl/ram_stream_reader_skid_fifo2.sv
// Two-entry synchronous FIFO carrying a data word plus its last flag; the head
// entry drives the stream directly, so it stays put until popped.
module skid_fifo2
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [1:0]        occ,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last
);

    logic [DATA_W-1:0] data_q [2];
    logic [1:0]        last_q;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the entries are reset because the head entry is the visible out_data, which must read 0.
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q    <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= push_data;
                last_q[wr_ptr] <= push_last;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);
    assign occ       = count;
    assign head_data = data_q[rd_ptr];
    assign head_last = last_q[rd_ptr];

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a contiguous RAM word range and emits it as a valid/ready stream.
// Optional RD_CHECKSUM_EN adds a running 32-bit sum of the handshaked words.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [LEN_W-1:0]     length,
    output logic                 busy,
    output logic                 done,
`ifdef RD_CHECKSUM_EN
    output logic [31:0]          checksum,
`endif
    ram_stream_reader_if.master  rd
);

    state_t            state, state_n;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rd_cnt;
    logic [LEN_W-1:0]  rd_cnt_inc;
    logic [ADDR_W-1:0] addr_q;
    logic              issue, issue_last, done_n;

    // p1: a read was issued last edge; dv: ram_data_out holds an uncaptured word.
    logic              p1, p1_last;
    logic              dv, dv_last;

    logic              full, empty, push, pop;
    logic [1:0]        occ, occ_next;
    logic [DATA_W-1:0] head_data;
    logic              head_last;
    logic              dv_next, room;
    logic              done_q;

    assign pop        = !empty && rd.out_ready;
    assign push       = dv && (!full || pop);
    assign occ_next   = occ - {1'b0, pop} + {1'b0, push};
    assign dv_next    = p1 || (dv && !push);
    assign rd_cnt_inc = rd_cnt + 1'b1;

    // With the address held, the RAM keeps presenting the last word, which acts
    // as a third slot; a new read is only safe if that word can land next edge.
    assign room = !dv_next || (occ_next <= 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_n    = state;
        issue      = 1'b0;
        issue_last = 1'b0;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_n = 1'b1;
                    end else begin
                        issue      = 1'b1;
                        issue_last = (length == LEN_W'(1));
                        state_n    = RUN;
                    end
                end
            end
            RUN: begin
                if (rd_cnt == len_q) begin
                    state_n = DRAIN;
                end else if (room) begin
                    issue      = 1'b1;
                    issue_last = (rd_cnt_inc == len_q);
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            rd_cnt  <= '0;
            addr_q  <= '0;
            p1      <= 1'b0;
            p1_last <= 1'b0;
            dv      <= 1'b0;
            dv_last <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q  <= done_n;
            p1      <= issue;
            p1_last <= issue_last;
            if (state == IDLE && start) begin
                len_q <= length;
            end
            if (issue) begin
                addr_q <= (state == IDLE) ? base_addr : addr_q + 1'b1;
                rd_cnt <= (state == IDLE) ? LEN_W'(1) : rd_cnt_inc;
            end
            if (p1) begin
                dv      <= 1'b1;
                dv_last <= p1_last;
            end else if (push) begin
                dv <= 1'b0;
            end
        end
    end

    skid_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (rd.ram_data_out),
        .push_last (dv_last),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .occ       (occ),
        .head_data (head_data),
        .head_last (head_last)
    );

`ifdef RD_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (state == IDLE && start) begin
            sum_q <= '0;
        end else if (pop) begin
            sum_q <= sum_q + head_data[31:0];
        end
    end

    assign checksum = sum_q;
`endif

    assign busy           = (state != IDLE);
    assign done           = done_q;
    assign rd.ram_we      = 1'b0;
    assign rd.ram_data_in = '0;
    assign rd.ram_addr    = addr_q;
    assign rd.out_valid   = !empty;
    assign rd.out_data    = head_data;
    assign rd.out_last    = head_last;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: stimulus pushes expected words, a
// negedge monitor pops and compares on every handshake.
module tb_ram_stream_reader;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic [11:0] length;
    logic        busy;
    logic        done;
`ifdef RD_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    ram_stream_reader_if #(.ADDR_W(12), .DATA_W(32)) rd_bus ();

    ram_stream_reader #(.ADDR_W(12), .LEN_W(12), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
`ifdef RD_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .rd        (rd_bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [4096];
    always @(posedge clk) rd_bus.ram_data_out <= mem[rd_bus.ram_addr];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    exp_t        exp_q [$];
    int          hs_cyc [$];
    logic [11:0] addr_log [$];
    int          hs_count   = 0;
    int          done_count = 0;
    int          done_cyc   = -1;
    int          valid_seen = 0;
    int          start_cyc  = 0;
    logic        ready_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard compare, stall-stability, done and address tracking.
    logic        stalled   = 1'b0;
    logic [31:0] held_data = '0;
    logic        held_last = 1'b0;
    logic [11:0] last_addr = '0;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid_held", 32'(rd_bus.out_valid), 32'd1);
                check("stall_data_held", rd_bus.out_data, held_data);
                check("stall_last_held", 32'(rd_bus.out_last), 32'(held_last));
            end
            if (rd_bus.out_valid) valid_seen++;
            if (rd_bus.out_valid && rd_bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%08h with nothing expected", rd_bus.out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("stream_data", rd_bus.out_data, e.data);
                    check("stream_last", 32'(rd_bus.out_last), 32'(e.last));
                end
                hs_count++;
                hs_cyc.push_back(cyc);
            end
            stalled   = rd_bus.out_valid && !rd_bus.out_ready;
            held_data = rd_bus.out_data;
            held_last = rd_bus.out_last;
            if (done) begin
                done_count++;
                done_cyc = cyc;
                check("busy_low_at_done", 32'(busy), 32'd0);
            end
            if (rd_bus.ram_addr != last_addr) begin
                addr_log.push_back(rd_bus.ram_addr);
                last_addr = rd_bus.ram_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic exp_range(input logic [11:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            logic [11:0] a;
            a = base + 12'(i);
            push_exp(32'h100 + 32'(a), i == len - 1);
        end
    endtask

    task automatic issue_cmd(input logic [11:0] base, input logic [11:0] len);
        start     = 1'b1;
        base_addr = base;
        length    = len;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input bit toggle);
        int dc0;
        bit got;
        dc0 = done_count;
        got = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            if (toggle) out_ready_set(ready_pat[k % 6]);
            tick();
            if (done_count != dc0) begin
                got = 1'b1;
                break;
            end
        end
        out_ready_set(1'b1);
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
        end
    endtask

    task automatic out_ready_set(input logic v);
        rd_bus.out_ready = v;
    endtask

    initial begin
        int c, hs0, dc0, vs0;
        bit got;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h100 + 32'(i);
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        out_ready_set(1'b0);
        repeat (3) tick();

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_valid", 32'(rd_bus.out_valid), 32'd0);
        check("rst_out_last", 32'(rd_bus.out_last), 32'd0);
        check("rst_out_data", rd_bus.out_data, 32'd0);
        check("rst_ram_addr", 32'(rd_bus.ram_addr), 32'd0);
        check("rst_ram_we", 32'(rd_bus.ram_we), 32'd0);
        check("rst_ram_data_in", rd_bus.ram_data_in, 32'd0);
        rst = 1'b0;
        tick();

        // Basic 4-word command, full throughput and exact timing.
        out_ready_set(1'b1);
        hs_cyc.delete();
        push_exp(32'h110, 1'b0);
        push_exp(32'h111, 1'b0);
        push_exp(32'h112, 1'b0);
        push_exp(32'h113, 1'b1);
        issue_cmd(12'h010, 12'd4);
        c = start_cyc;
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(40, 1'b0);
        check("t1_word_count", 32'(hs_cyc.size()), 32'd4);
        if (hs_cyc.size() == 4) begin
            check("t1_first_word_cycle", 32'(hs_cyc[0] - c), 32'd3);
            check("t1_last_word_cycle", 32'(hs_cyc[3] - c), 32'd6);
        end
        check("t1_done_cycle", 32'(done_cyc - c), 32'd7);
        check("t1_queue_drained", 32'(exp_q.size()), 32'd0);

        // Same command under toggling backpressure.
        hs0 = hs_count;
        exp_range(12'h010, 4);
        issue_cmd(12'h010, 12'd4);
        wait_done(60, 1'b1);
        check("t2_word_count", 32'(hs_count - hs0), 32'd4);
        check("t2_queue_drained", 32'(exp_q.size()), 32'd0);

        // Address wrap at the top of the RAM.
        addr_log.delete();
        push_exp(32'h10FE, 1'b0);
        push_exp(32'h10FF, 1'b0);
        push_exp(32'h0100, 1'b1);
        issue_cmd(12'hFFE, 12'd3);
        wait_done(40, 1'b0);
        check("t3_addr_count", 32'(addr_log.size()), 32'd3);
        if (addr_log.size() == 3) begin
            check("t3_addr0", 32'(addr_log[0]), 32'hFFE);
            check("t3_addr1", 32'(addr_log[1]), 32'hFFF);
            check("t3_addr2", 32'(addr_log[2]), 32'h000);
        end
        check("t3_queue_drained", 32'(exp_q.size()), 32'd0);

        // Zero-length command.
        vs0 = valid_seen;
        dc0 = done_count;
        issue_cmd(12'h123, 12'd0);
        c = start_cyc;
        wait_done(10, 1'b0);
        check("t4_done_cycle", 32'(done_cyc - c), 32'd1);
        repeat (4) tick();
        check("t4_no_valid", 32'(valid_seen - vs0), 32'd0);
        check("t4_one_done", 32'(done_count - dc0), 32'd1);
        check("t4_not_busy", 32'(busy), 32'd0);

        // Start while busy must be ignored.
        hs0 = hs_count;
        dc0 = done_count;
        exp_range(12'h020, 8);
        issue_cmd(12'h020, 12'd8);
        tick();
        check("t5_busy_mid_run", 32'(busy), 32'd1);
        start = 1'b1;
        base_addr = 12'h300;
        length = 12'd5;
        tick();
        start = 1'b0;
        wait_done(60, 1'b0);
        repeat (5) tick();
        check("t5_word_count", 32'(hs_count - hs0), 32'd8);
        check("t5_one_done", 32'(done_count - dc0), 32'd1);
        check("t5_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset after 2 of 6 words, then a fresh command.
        hs0 = hs_count;
        exp_range(12'h040, 6);
        issue_cmd(12'h040, 12'd6);
        got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (hs_count - hs0 >= 2) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL t6_two_words_timeout: saw %0d words", hs_count - hs0);
        end
        rst = 1'b1;
        out_ready_set(1'b0);
        dc0 = done_count;
        tick();
        check("t6_rst_out_valid", 32'(rd_bus.out_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_words_before_rst", 32'(hs_count - hs0), 32'd2);
        exp_q.delete();
        rst = 1'b0;
        repeat (3) tick();
        check("t6_no_done_after_rst", 32'(done_count - dc0), 32'd0);
        out_ready_set(1'b1);
        hs0 = hs_count;
        exp_range(12'h050, 3);
        issue_cmd(12'h050, 12'd3);
        wait_done(40, 1'b0);
        check("t6_fresh_word_count", 32'(hs_count - hs0), 32'd3);
        check("t6_queue_drained", 32'(exp_q.size()), 32'd0);

`ifdef RD_CHECKSUM_EN
        // Checksum wraps modulo 2^32: 1 + 2 + 0xFFFFFFFF = 2.
        mem[0] = 32'h0000_0001;
        mem[1] = 32'h0000_0002;
        mem[2] = 32'hFFFF_FFFF;
        push_exp(32'h0000_0001, 1'b0);
        push_exp(32'h0000_0002, 1'b0);
        push_exp(32'hFFFF_FFFF, 1'b1);
        issue_cmd(12'h000, 12'd3);
        wait_done(40, 1'b0);
        check("t7_checksum", checksum, 32'h0000_0002);
        check("t7_queue_drained", 32'(exp_q.size()), 32'd0);
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
